// File: rtl/rob_ctrl_pkg.sv
// rob_ctrl_pkg: shared types and constants for the reorder-buffer controller
package rob_ctrl_pkg;
  localparam int ROB_WIDTH = 6;
  typedef enum logic [0:0] {RUN, RECOVER} rob_ctrl_state_e;
  typedef struct packed {
    logic [ROB_WIDTH-1:0] head;
    logic [ROB_WIDTH-1:0] tail;
    logic [ROB_WIDTH:0]   cnt;
    logic                 empty;
    logic                 full;
  } rob_ctrl_status_t;
endpackage

// File: rtl/rob_commit_sel.sv
// rob_commit_sel: in-order retire selection for the two oldest ROB entries
module rob_commit_sel #(
  parameter int CW = 7
) (
  input  logic          run,
  input  logic          stall,
  input  logic [1:0]    valid,
  input  logic [1:0]    single,
  input  logic [CW-1:0] cnt,
  output logic [1:0]    req
);
  assign req[0] = run & ~stall & valid[0] & (cnt != '0);
  assign req[1] = req[0] & valid[1] & (cnt > CW'(1)) & ~|single;
endmodule

// File: rtl/rob_ctrl.sv
// rob_ctrl: ROB allocation/retire pointers, occupancy and post-flush recovery
module rob_ctrl #(
  parameter int ROB_WIDTH      = rob_ctrl_pkg::ROB_WIDTH,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  input  logic [1:0]                dispatch_req_i,
  output logic                      dispatch_ready_o,
  output logic [1:0][ROB_WIDTH-1:0] dispatch_rob_id_o,
  input  logic [1:0]                commit_valid_i,
  input  logic [1:0]                commit_single_i,
  input  logic                      commit_stall_i,
  output logic [1:0]                commit_req_o,
  output logic [ROB_WIDTH-1:0]      head_ptr_o,
  output logic [ROB_WIDTH-1:0]      tail_ptr_o,
  output logic [ROB_WIDTH:0]        rob_cnt_o,
  output logic                      rob_empty_o,
  output logic                      rob_full_o,
  output logic                      recovering_o
);
  import rob_ctrl_pkg::*;
  localparam int DEPTH = 1 << ROB_WIDTH;
  localparam int CW    = ROB_WIDTH + 1;
  rob_ctrl_state_e      state_q, state_d;
  logic [3:0]           rcnt_q, rcnt_d;
  logic [ROB_WIDTH-1:0] head_q, tail_q;
  logic [CW-1:0]        cnt_q;
  logic [1:0]           alloc_n, ret_n;
  logic                 run;
  assign run              = (state_q == RUN) & ~flush_i;
  assign dispatch_ready_o = run & (cnt_q <= CW'(DEPTH - 2));
  assign dispatch_rob_id_o[0] = head_q;
  assign dispatch_rob_id_o[1] = head_q + ROB_WIDTH'(1);
  assign alloc_n = dispatch_ready_o ? 2'(dispatch_req_i[0]) + 2'(dispatch_req_i[1]) : 2'd0;
  assign ret_n   = 2'(commit_req_o[0]) + 2'(commit_req_o[1]);
  assign head_ptr_o   = head_q;
  assign tail_ptr_o   = tail_q;
  assign rob_cnt_o    = cnt_q;
  assign rob_empty_o  = cnt_q == '0;
  assign rob_full_o   = cnt_q >= CW'(DEPTH - 1);
  assign recovering_o = state_q == RECOVER;
  rob_commit_sel #(.CW(CW)) u_commit_sel (
    .run    (run),
    .stall  (commit_stall_i),
    .valid  (commit_valid_i),
    .single (commit_single_i),
    .cnt    (cnt_q),
    .req    (commit_req_o)
  );
  // flush (re)arms the recovery countdown; RECOVER exits once it reaches zero
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    if (flush_i) begin
      state_d = RECOVER;
      rcnt_d  = 4'(RECOVER_CYCLES - 1);
    end else if (state_q == RECOVER) begin
      state_d = (rcnt_q == '0) ? RUN : RECOVER;
      rcnt_d  = (rcnt_q == '0) ? rcnt_q : rcnt_q - 4'd1;
    end
  end
  // state, pointers and occupancy; flush clears the buffer outright
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      rcnt_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      head_q  <= flush_i ? '0 : head_q + ROB_WIDTH'(alloc_n);
      tail_q  <= flush_i ? '0 : tail_q + ROB_WIDTH'(ret_n);
      cnt_q   <= flush_i ? '0 : cnt_q + CW'(alloc_n) - CW'(ret_n);
    end
  end
  // simulation sanity checks on occupancy and request encoding
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (cnt_q <= CW'(DEPTH));
      assert (cnt_q + CW'(alloc_n) >= CW'(ret_n));
      assert (dispatch_req_i != 2'b10);
    end
  end
endmodule

// File: tb/tb_rob_ctrl.sv
// tb_rob_ctrl: directed checks of dispatch, commit, wrap and flush recovery
module tb_rob_ctrl;
  logic            clk = 0, rst_n = 0, flush = 0, stall = 0;
  logic [1:0]      req = 0, valid = 0, single = 0, creq;
  logic            ready, empty, full, rec;
  logic [1:0][5:0] ids;
  logic [5:0]      head, tail;
  logic [6:0]      cnt;
  int              tests = 0, fails = 0;
  always #5 clk = ~clk;
  rob_ctrl #(.ROB_WIDTH(6), .RECOVER_CYCLES(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flush_i           (flush),
    .dispatch_req_i    (req),
    .dispatch_ready_o  (ready),
    .dispatch_rob_id_o (ids),
    .commit_valid_i    (valid),
    .commit_single_i   (single),
    .commit_stall_i    (stall),
    .commit_req_o      (creq),
    .head_ptr_o        (head),
    .tail_ptr_o        (tail),
    .rob_cnt_o         (cnt),
    .rob_empty_o       (empty),
    .rob_full_o        (full),
    .recovering_o      (rec)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst_n = 0;
    tick;
    tick;
    #1 tests++;
    if ({head, tail, cnt} !== {6'd0, 6'd0, 7'd0}) begin
      fails++;
      $display("FAIL reset_ptrs: head=%0d tail=%0d cnt=%0d, want 0/0/0", head, tail, cnt);
    end
    tests++;
    if ({empty, full, rec, creq} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_flags: empty,full,rec,creq=%b, want 10000", {empty, full, rec, creq});
    end
    rst_n = 1;
    #1 tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b want 1", ready);
    end
  endtask
  task automatic test_fill;
    req = 2'b11;
    for (int i = 0; i < 32; i++) begin
      #1 tests++;
      if ({ready, ids[1], ids[0]} !== {1'b1, 6'(2 * i + 1), 6'(2 * i)}) begin
        fails++;
        $display("FAIL fill_ids[%0d]: ready=%b ids=%0d,%0d want 1 %0d,%0d", i, ready, ids[0], ids[1], 2 * i, 2 * i + 1);
      end
      tick;
    end
    #1 tests++;
    if ({head, tail, cnt, full, ready, empty} !== {6'd0, 6'd0, 7'd64, 3'b100}) begin
      fails++;
      $display("FAIL fill_full: head=%0d tail=%0d cnt=%0d full=%b ready=%b empty=%b, want 0/0/64 1 0 0", head, tail, cnt, full, ready, empty);
    end
    req = 2'b00;
  endtask
  task automatic test_full_boundary;
    valid = 2'b01;
    #1 tests++;
    if (creq !== 2'b01) begin
      fails++;
      $display("FAIL full_commit_one: creq=%b want 01", creq);
    end
    tick;
    valid = 2'b00;
    req = 2'b01;
    #1 tests++;
    if ({ready, full, tail, cnt} !== {2'b01, 6'd1, 7'd63}) begin
      fails++;
      $display("FAIL cnt63_ready: ready=%b full=%b tail=%0d cnt=%0d, want 0 1 1 63", ready, full, tail, cnt);
    end
    tick;
    #1 tests++;
    if ({head, cnt} !== {6'd0, 7'd63}) begin
      fails++;
      $display("FAIL cnt63_no_alloc: head=%0d cnt=%0d, want 0 63", head, cnt);
    end
    req = 2'b00;
    valid = 2'b01;
    tick;
    valid = 2'b00;
    #1 tests++;
    if ({ready, full, tail, cnt} !== {2'b10, 6'd2, 7'd62}) begin
      fails++;
      $display("FAIL cnt62_ready: ready=%b full=%b tail=%0d cnt=%0d, want 1 0 2 62", ready, full, tail, cnt);
    end
  endtask
  task automatic test_commit;
    valid = 2'b11;
    repeat (29) tick;
    #1 tests++;
    if ({head, tail, cnt} !== {6'd0, 6'd60, 7'd4}) begin
      fails++;
      $display("FAIL pair_drain: head=%0d tail=%0d cnt=%0d, want 0/60/4", head, tail, cnt);
    end
    single = 2'b10;
    #1 tests++;
    if (creq !== 2'b01) begin
      fails++;
      $display("FAIL single_slot1: creq=%b want 01", creq);
    end
    tick;
    single = 2'b01;
    #1 tests++;
    if ({creq, tail, cnt} !== {2'b01, 6'd61, 7'd3}) begin
      fails++;
      $display("FAIL single_slot0: creq=%b tail=%0d cnt=%0d, want 01 61 3", creq, tail, cnt);
    end
    tick;
    single = 2'b00;
    stall = 1;
    #1 tests++;
    if ({creq, tail, cnt} !== {2'b00, 6'd62, 7'd2}) begin
      fails++;
      $display("FAIL stall: creq=%b tail=%0d cnt=%0d, want 00 62 2", creq, tail, cnt);
    end
    tick;
    stall = 0;
    #1 tests++;
    if ({creq, tail, cnt} !== {2'b11, 6'd62, 7'd2}) begin
      fails++;
      $display("FAIL commit_pair: creq=%b tail=%0d cnt=%0d, want 11 62 2", creq, tail, cnt);
    end
    tick;
    #1 tests++;
    if ({creq, tail, cnt, empty} !== {2'b00, 6'd0, 7'd0, 1'b1}) begin
      fails++;
      $display("FAIL empty_no_commit: creq=%b tail=%0d cnt=%0d empty=%b, want 00 0 0 1", creq, tail, cnt, empty);
    end
    valid = 2'b00;
  endtask
  task automatic test_wrap;
    rst_n = 0;
    tick;
    rst_n = 1;
    req = 2'b11;
    repeat (31) tick;
    req = 2'b00;
    valid = 2'b11;
    repeat (31) tick;
    valid = 2'b00;
    #1 tests++;
    if ({head, tail, cnt} !== {6'd62, 6'd62, 7'd0}) begin
      fails++;
      $display("FAIL wrap_setup: head=%0d tail=%0d cnt=%0d, want 62/62/0", head, tail, cnt);
    end
    req = 2'b11;
    #1 tests++;
    if ({ids[1], ids[0]} !== {6'd63, 6'd62}) begin
      fails++;
      $display("FAIL wrap_ids_a: ids=%0d,%0d want 62,63", ids[0], ids[1]);
    end
    tick;
    valid = 2'b11;
    #1 tests++;
    if ({ids[1], ids[0], creq, head, cnt} !== {6'd1, 6'd0, 2'b11, 6'd0, 7'd2}) begin
      fails++;
      $display("FAIL wrap_ids_b: ids=%0d,%0d creq=%b head=%0d cnt=%0d, want 0,1 11 0 2", ids[0], ids[1], creq, head, cnt);
    end
    tick;
    req = 2'b00;
    valid = 2'b01;
    #1 tests++;
    if ({head, tail, cnt, creq} !== {6'd2, 6'd0, 7'd2, 2'b01}) begin
      fails++;
      $display("FAIL wrap_final: head=%0d tail=%0d cnt=%0d creq=%b, want 2/0/2 01", head, tail, cnt, creq);
    end
    tick;
    valid = 2'b11;
    #1 tests++;
    if ({creq, tail, cnt} !== {2'b01, 6'd1, 7'd1}) begin
      fails++;
      $display("FAIL cnt1_single: creq=%b tail=%0d cnt=%0d, want 01 1 1", creq, tail, cnt);
    end
    tick;
    valid = 2'b00;
    #1 tests++;
    if ({tail, cnt, empty} !== {6'd2, 7'd0, 1'b1}) begin
      fails++;
      $display("FAIL cnt1_drain: tail=%0d cnt=%0d empty=%b, want 2 0 1", tail, cnt, empty);
    end
  endtask
  task automatic test_flush;
    req = 2'b11;
    repeat (5) tick;
    valid = 2'b11;
    flush = 1;
    #1 tests++;
    if ({creq, ready, head, cnt} !== {3'b000, 6'd12, 7'd10}) begin
      fails++;
      $display("FAIL flush_same_cycle: creq=%b ready=%b head=%0d cnt=%0d, want 00 0 12 10", creq, ready, head, cnt);
    end
    tick;
    flush = 0;
    req = 2'b00;
    valid = 2'b00;
    #1 tests++;
    if ({head, tail, cnt, rec, ready} !== {6'd0, 6'd0, 7'd0, 2'b10}) begin
      fails++;
      $display("FAIL flush_next: head=%0d tail=%0d cnt=%0d rec=%b ready=%b, want 0/0/0 1 0", head, tail, cnt, rec, ready);
    end
    tick;
    #1 tests++;
    if ({rec, ready} !== 2'b10) begin
      fails++;
      $display("FAIL recover_2nd: rec=%b ready=%b want 1 0", rec, ready);
    end
    tick;
    #1 tests++;
    if ({rec, ready} !== 2'b01) begin
      fails++;
      $display("FAIL recover_exit: rec=%b ready=%b want 0 1", rec, ready);
    end
  endtask
  task automatic test_reflush;
    flush = 1;
    tick;
    flush = 0;
    tick;
    #1 tests++;
    if ({rec, ready} !== 2'b10) begin
      fails++;
      $display("FAIL reflush_pre: rec=%b ready=%b want 1 0", rec, ready);
    end
    flush = 1;
    tick;
    flush = 0;
    #1 tests++;
    if (rec !== 1'b1) begin
      fails++;
      $display("FAIL reflush_1: rec=%b want 1", rec);
    end
    tick;
    #1 tests++;
    if ({rec, ready} !== 2'b10) begin
      fails++;
      $display("FAIL reflush_2: rec=%b ready=%b want 1 0", rec, ready);
    end
    tick;
    #1 tests++;
    if ({rec, ready} !== 2'b01) begin
      fails++;
      $display("FAIL reflush_exit: rec=%b ready=%b want 0 1", rec, ready);
    end
  endtask
  initial begin
    test_reset;
    test_fill;
    test_full_boundary;
    test_commit;
    test_wrap;
    test_flush;
    test_reflush;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rob_ctrl.md
Name: rob_ctrl

Overview:
- Sequencing controller for the 64-entry reorder buffer.
- Owns the allocation (head) and retirement (tail) pointers and the occupancy count.
- Hands out ROB IDs to the two dispatch slots, back-pressures dispatch when the buffer is full, and decides each cycle how many completed oldest entries retire.
- Runs a post-flush recovery sequence. Sits between rename/dispatch, the ROB tables and the commit stage.

Parameters:
- ROB_WIDTH, 6, log2 of ROB depth. DEPTH = 1 << ROB_WIDTH.
- RECOVER_CYCLES, 2, cycles that dispatch and commit stay blocked after a flush. Legal range is 1..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- flush_i  in  1  pipeline flush (exception, branch mispredict, ertn).
- dispatch_req_i  in  2  per-slot allocation request. bit1 set implies bit0 set.
- dispatch_ready_o  out  1  both slots may allocate this cycle.
- dispatch_rob_id_o  out  2xROB_WIDTH  IDs for slot0/slot1 this cycle.
- commit_valid_i  in  2  oldest and second-oldest entries are complete (from ROB).
- commit_single_i  in  2  entry must retire alone (CSR, TLB, cacop, ll/sc, idle, any exception).
- commit_stall_i  in  1  commit stage cannot accept, e.g. store buffer full.
- commit_req_o  out  2  retire oldest / second-oldest this cycle. Goes to ROB and commit stage.
- head_ptr_o  out  ROB_WIDTH  next allocation index.
- tail_ptr_o  out  ROB_WIDTH  oldest entry index.
- rob_cnt_o  out  ROB_WIDTH+1  occupied entries.
- rob_empty_o  out  1  rob_cnt_o == 0.
- rob_full_o  out  1  DEPTH - rob_cnt_o < 2.
- recovering_o  out  1  state is RECOVER.

Behaviour:
- **Reset.** Reset values: head 0, tail 0, cnt 0, state RUN, recover counter 0. Resulting outputs: rob_empty_o=1, rob_full_o=0, recovering_o=0, commit_req_o=0.
- **State machine.** Two states, RUN and RECOVER.
  - RUN -> RECOVER on flush_i; the counter loads RECOVER_CYCLES-1.
  - RECOVER decrements the counter each cycle and goes to RUN when the counter is 0.
  - flush_i in RECOVER reloads the counter.
- **Dispatch.**
  - dispatch_ready_o = (state==RUN) & !flush_i & (DEPTH - cnt >= 2). This is combinational.
  - Allocation is all-or-nothing per cycle: an allocation happens only when dispatch_ready_o & dispatch_req_i[k].
  - dispatch_rob_id_o[0] = head and dispatch_rob_id_o[1] = head+1, both mod DEPTH. Valid regardless of req.
  - alloc_n = number of accepted slots (0..2).
  - Requests while not ready are ignored. The upstream stage holds them.
- **Commit.** commit_req_o is combinational and same-cycle, because the ROB advances its tail on it.
  - commit_req_o[0] = (state==RUN) & !flush_i & !commit_stall_i & commit_valid_i[0] & (cnt>0).
  - commit_req_o[1] = commit_req_o[0] & commit_valid_i[1] & (cnt>1) & !commit_single_i[0] & !commit_single_i[1].
  - Retirement is strictly in order: slot1 never retires without slot0.
- **Pointer and count update.** Registered, when not flushing:
  - head += alloc_n, tail += ret_n, both wrapping mod DEPTH.
  - cnt += alloc_n - ret_n, computed at ROB_WIDTH+1 bits. Simultaneous alloc and retire in one cycle is legal.
- **Flush.** flush_i has priority over every same-cycle dispatch and commit event.
  - Next cycle: head=tail=cnt=0 and state RECOVER.
  - During RECOVER: dispatch_ready_o=0, commit_req_o=0, recovering_o=1.
- **Boundaries.**
  - cnt==DEPTH-1 gives ready=0, so one free entry is never allocated alone.
  - cnt==1 makes commit_req_o[1] 0 even if commit_valid_i[1]=1.
  - Wrap: head=63 gives IDs {63,0}.
- **Assertions (sim only).** cnt never exceeds DEPTH. cnt never underflows. dispatch_req_i != 2'b10.

Decomposition:
- Shared package (a_defines): ROB_WIDTH constant, rob_ctrl_state_e {RUN, RECOVER}, and a rob_ctrl_status_t struct bundling head/tail/cnt/empty/full for debug and perf counters.
- Sub-module rob_commit_sel: purely combinational commit_req generation from valid/single/stall/cnt, so it can be tested in isolation.
- Pointer, count and FSM logic stay in rob_ctrl.

Test Plan:
- Reset, then dispatch_req=11 for 32 cycles with no commit -> IDs {0,1},{2,3}..{62,63}. Then cnt=64, rob_full_o=1, ready=0.
- cnt=63 with dispatch_req=01 -> ready=0 and head unchanged. Commit one (valid=01) -> next cycle cnt=62 and ready=1.
- cnt=4, commit_valid=11, single=10 -> commit_req=01, tail+1. With single=00 -> commit_req=11, tail+2. With stall=1 -> commit_req=00.
- head=tail=62, cnt=0: dispatch 11 ×2 with commit 11 in the second cycle -> IDs {62,63} then {0,1}. Final head=2, tail=0, cnt=2.
- cnt=10, flush_i=1 with dispatch_req=11 and commit_valid=11 in the same cycle:
  - Same cycle: commit_req=00, ready=0.
  - Next cycle: head=tail=cnt=0, recovering_o=1.
  - ready stays 0 for 2 cycles, returns to 1 in the third.
- Flush again during RECOVER -> counter reloads. recovering_o stays high 2 more cycles from the second flush.
